// File: rtl/axi_slave_ddr_model.sv
// AXI4 slave DDR emulator: INCR read/write bursts backed by a byte-strobed
// word memory, one outstanding read and one outstanding write, OKAY responses.
module axi_slave_ddr_model #(
  parameter int C_S_AXI_ID_WIDTH   = 1,
  parameter int C_S_AXI_LEN_WIDTH  = 32,
  parameter int C_S_AXI_SIZE_WIDTH = 3,
  parameter int C_S_AXI_USER_WIDTH = 1,
  parameter int C_S_AXI_ADDR_WIDTH = 32,
  parameter int C_S_AXI_DATA_WIDTH = 128,
  parameter int C_MEM_ADDR_WIDTH   = 10
) (
  input  logic                          I_clk,
  input  logic                          I_rst_n,
  // read address
  input  logic [C_S_AXI_ID_WIDTH-1:0]   I_saxi_arid,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0] I_saxi_araddr,
  input  logic [C_S_AXI_LEN_WIDTH-1:0]  I_saxi_arlen,
  input  logic [C_S_AXI_SIZE_WIDTH-1:0] I_saxi_arsize,
  input  logic [1:0]                    I_saxi_arburst,
  input  logic                          I_saxi_arlock,
  input  logic [3:0]                    I_saxi_arcache,
  input  logic [2:0]                    I_saxi_arprot,
  input  logic [3:0]                    I_saxi_arqos,
  input  logic [3:0]                    I_saxi_arregion,
  input  logic [C_S_AXI_USER_WIDTH-1:0] I_saxi_aruser,
  input  logic                          I_saxi_arvalid,
  output logic                          O_saxi_arready,
  // read data
  output logic [C_S_AXI_ID_WIDTH-1:0]   O_saxi_rid,
  output logic [C_S_AXI_DATA_WIDTH-1:0] O_saxi_rdata,
  output logic [1:0]                    O_saxi_rresp,
  output logic [C_S_AXI_USER_WIDTH-1:0] O_saxi_ruser,
  output logic [1:0]                    O_saxi_rlast,
  output logic                          O_saxi_rvalid,
  input  logic                          I_saxi_rready,
  // write address
  input  logic [C_S_AXI_ID_WIDTH-1:0]   I_saxi_awid,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0] I_saxi_awaddr,
  input  logic [C_S_AXI_LEN_WIDTH-1:0]  I_saxi_awlen,
  input  logic [C_S_AXI_SIZE_WIDTH-1:0] I_saxi_awsize,
  input  logic [1:0]                    I_saxi_awburst,
  input  logic                          I_saxi_awlock,
  input  logic [3:0]                    I_saxi_awcache,
  input  logic [2:0]                    I_saxi_awprot,
  input  logic [3:0]                    I_saxi_awqos,
  input  logic [3:0]                    I_saxi_awregion,
  input  logic [C_S_AXI_USER_WIDTH-1:0] I_saxi_awuser,
  input  logic                          I_saxi_awvalid,
  output logic                          O_saxi_awready,
  // write data
  input  logic [C_S_AXI_ID_WIDTH-1:0]   I_saxi_wid,
  input  logic [C_S_AXI_DATA_WIDTH-1:0] I_saxi_wdata,
  input  logic [C_S_AXI_DATA_WIDTH/8-1:0] I_saxi_wstrb,
  input  logic [1:0]                    I_saxi_wlast,
  input  logic [C_S_AXI_USER_WIDTH-1:0] I_saxi_wuser,
  input  logic                          I_saxi_wvalid,
  output logic                          O_saxi_wready,
  // write response
  output logic [C_S_AXI_ID_WIDTH-1:0]   O_saxi_bid,
  output logic [1:0]                    O_saxi_bresp,
  output logic [C_S_AXI_USER_WIDTH-1:0] O_saxi_buser,
  output logic                          O_saxi_bvalid,
  input  logic                          I_saxi_bready
);

  localparam int DEPTH = 1 << C_MEM_ADDR_WIDTH;
  localparam int LANES = C_S_AXI_DATA_WIDTH / 8;
  localparam int CNT_W = C_S_AXI_LEN_WIDTH + 1;
  localparam logic [CNT_W-1:0]            CNT_ONE = CNT_W'(1);
  localparam logic [C_MEM_ADDR_WIDTH-1:0] IDX_ONE = C_MEM_ADDR_WIDTH'(1);

  typedef enum logic [1:0] {R_IDLE, R_FETCH, R_DATA} rstate_t;
  typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} wstate_t;

  logic [C_S_AXI_DATA_WIDTH-1:0] mem_q [0:DEPTH-1];

  logic                          run_q;
  rstate_t                       r_state_q, r_state_d;
  logic [C_S_AXI_ID_WIDTH-1:0]   r_id_q, r_id_d;
  logic [C_MEM_ADDR_WIDTH-1:0]   r_idx_q, r_idx_d;
  logic [CNT_W-1:0]              r_cnt_q, r_cnt_d;
  logic [C_S_AXI_DATA_WIDTH-1:0] r_data_q;
  logic                          r_last;

  wstate_t                       w_state_q, w_state_d;
  logic [C_S_AXI_ID_WIDTH-1:0]   w_id_q, w_id_d;
  logic [C_MEM_ADDR_WIDTH-1:0]   w_idx_q, w_idx_d;
  logic [CNT_W-1:0]              w_cnt_q, w_cnt_d;
  logic                          w_fire;

  // Sideband and sub-word address bits carry no meaning for this model.
  logic unused_inputs;
  assign unused_inputs = ^{I_saxi_arsize, I_saxi_arburst, I_saxi_arlock, I_saxi_arcache,
                           I_saxi_arprot, I_saxi_arqos, I_saxi_arregion, I_saxi_aruser,
                           I_saxi_araddr[C_S_AXI_ADDR_WIDTH-1:C_MEM_ADDR_WIDTH+4],
                           I_saxi_araddr[3:0],
                           I_saxi_awsize, I_saxi_awburst, I_saxi_awlock, I_saxi_awcache,
                           I_saxi_awprot, I_saxi_awqos, I_saxi_awregion, I_saxi_awuser,
                           I_saxi_awaddr[C_S_AXI_ADDR_WIDTH-1:C_MEM_ADDR_WIDTH+4],
                           I_saxi_awaddr[3:0], I_saxi_wid, I_saxi_wuser, I_saxi_wlast};

  // Holds the address-ready outputs low until the cycle after reset releases.
  always_ff @(posedge I_clk) begin
    if (!I_rst_n) run_q <= 1'b0;
    else          run_q <= 1'b1;
  end

  // Read FSM state and burst bookkeeping registers.
  always_ff @(posedge I_clk) begin
    if (!I_rst_n) begin
      r_state_q <= R_IDLE;
      r_id_q    <= '0;
      r_idx_q   <= '0;
      r_cnt_q   <= '0;
    end else begin
      r_state_q <= r_state_d;
      r_id_q    <= r_id_d;
      r_idx_q   <= r_idx_d;
      r_cnt_q   <= r_cnt_d;
    end
  end

  // Read next-state: fetch one word, present it, repeat until the count runs out.
  always_comb begin
    r_state_d = r_state_q;
    r_id_d    = r_id_q;
    r_idx_d   = r_idx_q;
    r_cnt_d   = r_cnt_q;
    case (r_state_q)
      R_IDLE: begin
        if (O_saxi_arready && I_saxi_arvalid) begin
          r_id_d    = I_saxi_arid;
          r_idx_d   = I_saxi_araddr[C_MEM_ADDR_WIDTH+3:4];
          r_cnt_d   = {1'b0, I_saxi_arlen} + CNT_ONE;
          r_state_d = R_FETCH;
        end
      end
      R_FETCH: r_state_d = R_DATA;
      R_DATA: begin
        if (I_saxi_rready) begin
          r_cnt_d   = r_cnt_q - CNT_ONE;
          r_idx_d   = r_idx_q + IDX_ONE;
          r_state_d = (r_cnt_q == CNT_ONE) ? R_IDLE : R_FETCH;
        end
      end
      default: r_state_d = R_IDLE;
    endcase
  end

  // Read channel outputs decoded from state.
  always_comb begin
    O_saxi_arready = run_q && (r_state_q == R_IDLE);
    O_saxi_rvalid  = (r_state_q == R_DATA);
    r_last         = (r_state_q == R_DATA) && (r_cnt_q == CNT_ONE);
  end

  // Registered memory read in the fetch cycle; held while the beat is stalled.
  always_ff @(posedge I_clk) begin
    if (!I_rst_n)                    r_data_q <= '0;
    else if (r_state_q == R_FETCH)   r_data_q <= mem_q[r_idx_q];
  end

  assign O_saxi_rid   = r_id_q;
  assign O_saxi_rdata = r_data_q;
  assign O_saxi_rresp = 2'b00;
  assign O_saxi_ruser = '0;
  assign O_saxi_rlast = {1'b0, r_last};

  // Write FSM state and burst bookkeeping registers.
  always_ff @(posedge I_clk) begin
    if (!I_rst_n) begin
      w_state_q <= W_IDLE;
      w_id_q    <= '0;
      w_idx_q   <= '0;
      w_cnt_q   <= '0;
    end else begin
      w_state_q <= w_state_d;
      w_id_q    <= w_id_d;
      w_idx_q   <= w_idx_d;
      w_cnt_q   <= w_cnt_d;
    end
  end

  // Write next-state: beat count alone ends the burst, wlast is not consulted.
  always_comb begin
    w_state_d = w_state_q;
    w_id_d    = w_id_q;
    w_idx_d   = w_idx_q;
    w_cnt_d   = w_cnt_q;
    case (w_state_q)
      W_IDLE: begin
        if (O_saxi_awready && I_saxi_awvalid) begin
          w_id_d    = I_saxi_awid;
          w_idx_d   = I_saxi_awaddr[C_MEM_ADDR_WIDTH+3:4];
          w_cnt_d   = {1'b0, I_saxi_awlen} + CNT_ONE;
          w_state_d = W_DATA;
        end
      end
      W_DATA: begin
        if (w_fire) begin
          w_cnt_d = w_cnt_q - CNT_ONE;
          w_idx_d = w_idx_q + IDX_ONE;
          if (w_cnt_q == CNT_ONE) w_state_d = W_RESP;
        end
      end
      W_RESP: if (I_saxi_bready) w_state_d = W_IDLE;
      default: w_state_d = W_IDLE;
    endcase
  end

  // Write channel outputs decoded from state.
  always_comb begin
    O_saxi_awready = run_q && (w_state_q == W_IDLE);
    O_saxi_wready  = (w_state_q == W_DATA);
    O_saxi_bvalid  = (w_state_q == W_RESP);
    w_fire         = O_saxi_wready && I_saxi_wvalid && I_rst_n;
  end

  // Byte-lane memory write; contents deliberately survive reset.
  always_ff @(posedge I_clk) begin
    if (w_fire) begin
      for (int i = 0; i < LANES; i++) begin
        if (I_saxi_wstrb[i]) mem_q[w_idx_q][8*i +: 8] <= I_saxi_wdata[8*i +: 8];
      end
    end
  end

  assign O_saxi_bid   = w_id_q;
  assign O_saxi_bresp = 2'b00;
  assign O_saxi_buser = '0;

endmodule

// File: tb/tb_axi_slave_ddr_model.sv
// Randomized bench for axi_slave_ddr_model against a word-array memory model.
module tb_axi_slave_ddr_model;

  localparam int DEPTH = 1024;

  logic         I_clk = 1'b0;
  logic         I_rst_n = 1'b0;
  logic [0:0]   I_saxi_arid = '0;
  logic [31:0]  I_saxi_araddr = '0;
  logic [31:0]  I_saxi_arlen = '0;
  logic [2:0]   I_saxi_arsize = 3'd4;
  logic [1:0]   I_saxi_arburst = 2'b01;
  logic         I_saxi_arlock = 1'b0;
  logic [3:0]   I_saxi_arcache = '0;
  logic [2:0]   I_saxi_arprot = '0;
  logic [3:0]   I_saxi_arqos = '0;
  logic [3:0]   I_saxi_arregion = '0;
  logic [0:0]   I_saxi_aruser = '0;
  logic         I_saxi_arvalid = 1'b0;
  logic         O_saxi_arready;
  logic [0:0]   O_saxi_rid;
  logic [127:0] O_saxi_rdata;
  logic [1:0]   O_saxi_rresp;
  logic [0:0]   O_saxi_ruser;
  logic [1:0]   O_saxi_rlast;
  logic         O_saxi_rvalid;
  logic         I_saxi_rready = 1'b0;
  logic [0:0]   I_saxi_awid = '0;
  logic [31:0]  I_saxi_awaddr = '0;
  logic [31:0]  I_saxi_awlen = '0;
  logic [2:0]   I_saxi_awsize = 3'd4;
  logic [1:0]   I_saxi_awburst = 2'b01;
  logic         I_saxi_awlock = 1'b0;
  logic [3:0]   I_saxi_awcache = '0;
  logic [2:0]   I_saxi_awprot = '0;
  logic [3:0]   I_saxi_awqos = '0;
  logic [3:0]   I_saxi_awregion = '0;
  logic [0:0]   I_saxi_awuser = '0;
  logic         I_saxi_awvalid = 1'b0;
  logic         O_saxi_awready;
  logic [0:0]   I_saxi_wid = '0;
  logic [127:0] I_saxi_wdata = '0;
  logic [15:0]  I_saxi_wstrb = '0;
  logic [1:0]   I_saxi_wlast = '0;
  logic [0:0]   I_saxi_wuser = '0;
  logic         I_saxi_wvalid = 1'b0;
  logic         O_saxi_wready;
  logic [0:0]   O_saxi_bid;
  logic [1:0]   O_saxi_bresp;
  logic [0:0]   O_saxi_buser;
  logic         O_saxi_bvalid;
  logic         I_saxi_bready = 1'b0;

  axi_slave_ddr_model dut (
    .I_clk(I_clk), .I_rst_n(I_rst_n),
    .I_saxi_arid(I_saxi_arid), .I_saxi_araddr(I_saxi_araddr), .I_saxi_arlen(I_saxi_arlen),
    .I_saxi_arsize(I_saxi_arsize), .I_saxi_arburst(I_saxi_arburst), .I_saxi_arlock(I_saxi_arlock),
    .I_saxi_arcache(I_saxi_arcache), .I_saxi_arprot(I_saxi_arprot), .I_saxi_arqos(I_saxi_arqos),
    .I_saxi_arregion(I_saxi_arregion), .I_saxi_aruser(I_saxi_aruser),
    .I_saxi_arvalid(I_saxi_arvalid), .O_saxi_arready(O_saxi_arready),
    .O_saxi_rid(O_saxi_rid), .O_saxi_rdata(O_saxi_rdata), .O_saxi_rresp(O_saxi_rresp),
    .O_saxi_ruser(O_saxi_ruser), .O_saxi_rlast(O_saxi_rlast), .O_saxi_rvalid(O_saxi_rvalid),
    .I_saxi_rready(I_saxi_rready),
    .I_saxi_awid(I_saxi_awid), .I_saxi_awaddr(I_saxi_awaddr), .I_saxi_awlen(I_saxi_awlen),
    .I_saxi_awsize(I_saxi_awsize), .I_saxi_awburst(I_saxi_awburst), .I_saxi_awlock(I_saxi_awlock),
    .I_saxi_awcache(I_saxi_awcache), .I_saxi_awprot(I_saxi_awprot), .I_saxi_awqos(I_saxi_awqos),
    .I_saxi_awregion(I_saxi_awregion), .I_saxi_awuser(I_saxi_awuser),
    .I_saxi_awvalid(I_saxi_awvalid), .O_saxi_awready(O_saxi_awready),
    .I_saxi_wid(I_saxi_wid), .I_saxi_wdata(I_saxi_wdata), .I_saxi_wstrb(I_saxi_wstrb),
    .I_saxi_wlast(I_saxi_wlast), .I_saxi_wuser(I_saxi_wuser),
    .I_saxi_wvalid(I_saxi_wvalid), .O_saxi_wready(O_saxi_wready),
    .O_saxi_bid(O_saxi_bid), .O_saxi_bresp(O_saxi_bresp), .O_saxi_buser(O_saxi_buser),
    .O_saxi_bvalid(O_saxi_bvalid), .I_saxi_bready(I_saxi_bready)
  );

  always #5 I_clk = ~I_clk;

  int n_chk  = 0;
  int n_pass = 0;

  logic [127:0] model [DEPTH];
  logic [127:0] wbuf_d [DEPTH];
  logic [15:0]  wbuf_s [DEPTH];

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  task automatic tb_abort(input string tag);
    chk(tag, 128'd0, 128'd1);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  endtask

  task automatic model_write(input int idx, input logic [127:0] d, input logic [15:0] s);
    for (int i = 0; i < 16; i++)
      if (s[i]) model[idx][8*i +: 8] = d[8*i +: 8];
  endtask

  // Burst write of wbuf_d/wbuf_s[0..len]; bad_last puts wlast on the first beat instead.
  task automatic axi_write(input logic [31:0] addr, input int len, input int bstall, input bit bad_last);
    int idx, cyc, k;
    bit hs;
    logic [0:0] id;
    idx = int'(addr[13:4]);
    id = 1'($urandom_range(0, 1));
    I_saxi_awid = id; I_saxi_awaddr = addr; I_saxi_awlen = len; I_saxi_awvalid = 1'b1;
    cyc = 0; hs = 0;
    while (!hs) begin
      @(negedge I_clk); hs = O_saxi_awready; cyc++;
      @(posedge I_clk); #1;
      if (!hs && cyc > 50) tb_abort("aw_timeout");
    end
    I_saxi_awvalid = 1'b0;
    for (int b = 0; b <= len; b++) begin
      I_saxi_wdata = wbuf_d[b];
      I_saxi_wstrb = wbuf_s[b];
      I_saxi_wlast = bad_last ? {1'b0, b == 0} : {1'b0, b == len};
      cyc = 0; hs = 0;
      while (!hs) begin
        I_saxi_wvalid = ($urandom_range(0, 3) != 0);
        @(negedge I_clk); cyc++;
        if (b == 0 && cyc == 1) chk("wready_lat", O_saxi_wready, 1);
        chk("awready_busy", O_saxi_awready, 0);
        hs = O_saxi_wready && I_saxi_wvalid;
        @(posedge I_clk); #1;
        if (!hs && cyc > 60) tb_abort("w_timeout");
      end
      model_write(idx, wbuf_d[b], wbuf_s[b]);
      idx = (idx + 1) % DEPTH;
    end
    I_saxi_wvalid = 1'b0;
    k = 0; hs = 0;
    while (!hs) begin
      I_saxi_bready = (k >= bstall);
      @(negedge I_clk);
      if (k == 0) chk("bvalid_lat", O_saxi_bvalid, 1);
      else        chk("bvalid_hold", O_saxi_bvalid, 1);
      hs = O_saxi_bvalid && I_saxi_bready;
      if (hs) begin
        chk("bid", O_saxi_bid, id);
        chk("bresp", O_saxi_bresp, 0);
      end
      @(posedge I_clk); #1; k++;
      if (!hs && k > bstall + 20) tb_abort("b_timeout");
    end
    I_saxi_bready = 1'b0;
  endtask

  // Burst read checked beat by beat against the model; stops early after max_beats.
  task automatic axi_read(input logic [31:0] addr, input int len, input bit rnd, input int max_beats);
    int idx, cyc, first;
    bit hs, hold_v;
    logic [127:0] hold_d;
    logic [1:0] hold_l;
    logic [0:0] id;
    idx = int'(addr[13:4]);
    id = 1'($urandom_range(0, 1));
    I_saxi_arid = id; I_saxi_araddr = addr; I_saxi_arlen = len; I_saxi_arvalid = 1'b1;
    cyc = 0; hs = 0;
    while (!hs) begin
      @(negedge I_clk); hs = O_saxi_arready; cyc++;
      @(posedge I_clk); #1;
      if (!hs && cyc > 50) tb_abort("ar_timeout");
    end
    I_saxi_arvalid = 1'b0;
    for (int b = 0; b <= len && b < max_beats; b++) begin
      cyc = 0; first = 0; hs = 0; hold_v = 0;
      while (!hs) begin
        I_saxi_rready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
        @(negedge I_clk); cyc++;
        chk("arready_busy", O_saxi_arready, 0);
        if (hold_v) begin
          chk("r_hold_valid", O_saxi_rvalid, 1);
          chk("r_hold_data", O_saxi_rdata, hold_d);
          chk("r_hold_last", O_saxi_rlast, hold_l);
        end
        if (O_saxi_rvalid) begin
          if (first == 0) begin
            first = cyc;
            chk("r_lat", cyc, 2);
          end
          if (I_saxi_rready) begin
            hs = 1;
            chk("rdata", O_saxi_rdata, model[idx]);
            chk("rlast", O_saxi_rlast, {1'b0, b == len});
            chk("rid", O_saxi_rid, id);
            chk("rresp", O_saxi_rresp, 0);
          end else begin
            hold_v = 1; hold_d = O_saxi_rdata; hold_l = O_saxi_rlast;
          end
        end
        @(posedge I_clk); #1;
        if (!hs && cyc > 60) tb_abort("r_timeout");
      end
      idx = (idx + 1) % DEPTH;
    end
    I_saxi_rready = 1'b0;
  endtask

  initial begin
    logic [127:0] old_d, new_d;
    // reset values
    repeat (3) @(posedge I_clk);
    @(negedge I_clk);
    chk("rst_arready", O_saxi_arready, 0);
    chk("rst_awready", O_saxi_awready, 0);
    chk("rst_wready", O_saxi_wready, 0);
    chk("rst_rvalid", O_saxi_rvalid, 0);
    chk("rst_bvalid", O_saxi_bvalid, 0);
    chk("rst_rlast", O_saxi_rlast, 0);
    chk("rst_rdata", O_saxi_rdata, 0);
    chk("rst_rid", O_saxi_rid, 0);
    chk("rst_bid", O_saxi_bid, 0);
    chk("rst_resp", {O_saxi_rresp, O_saxi_bresp}, 0);
    I_rst_n = 1'b1;
    @(negedge I_clk);
    chk("arready_after_rst", O_saxi_arready, 1);
    chk("awready_after_rst", O_saxi_awready, 1);
    @(posedge I_clk); #1;

    // fill the whole memory so every later read has a known value
    for (int i = 0; i < DEPTH; i++) begin
      wbuf_d[i] = {$urandom, $urandom, $urandom, $urandom};
      wbuf_s[i] = 16'hFFFF;
    end
    axi_write(32'h0, DEPTH - 1, 0, 0);

    // four-beat write and readback
    for (int i = 0; i < 4; i++) begin
      wbuf_d[i] = 128'(i);
      wbuf_s[i] = 16'hFFFF;
    end
    axi_write(32'h100, 3, 0, 0);
    axi_read(32'h100, 3, 0, 99);

    // partial strobes
    wbuf_d[0] = {16{8'hAA}}; wbuf_s[0] = 16'hFFFF;
    axi_write(32'h200, 0, 0, 0);
    wbuf_d[0] = {16{8'h55}}; wbuf_s[0] = 16'h00FF;
    axi_write(32'h200, 0, 0, 0);
    axi_read(32'h200, 0, 0, 99);

    // index wrap at the top of memory
    wbuf_d[0] = {4{$urandom}}; wbuf_d[1] = {4{$urandom}};
    wbuf_s[0] = 16'hFFFF; wbuf_s[1] = 16'hFFFF;
    axi_write(32'h3FF0, 1, 0, 0);
    axi_read(32'h0000, 0, 0, 99);
    axi_read(32'h3FF0, 1, 0, 99);

    // backpressure on both response channels, misplaced wlast
    for (int i = 0; i < 3; i++) begin
      wbuf_d[i] = {$urandom, $urandom, $urandom, $urandom};
      wbuf_s[i] = 16'($urandom);
    end
    axi_write(32'h800, 2, 5, 1);
    axi_read(32'h800, 2, 1, 99);

    // concurrent 16-beat write and 16-beat read on disjoint ranges
    for (int i = 0; i < 16; i++) begin
      wbuf_d[i] = {$urandom, $urandom, $urandom, $urandom};
      wbuf_s[i] = 16'hFFFF;
    end
    fork
      axi_write(32'h1000, 15, 2, 0);
      axi_read(32'h2000, 15, 1, 99);
    join
    axi_read(32'h1000, 15, 0, 99);

    // same-word read and write in one cycle: read sees the old word
    old_d = model[5];
    new_d = {$urandom, $urandom, $urandom, $urandom};
    I_saxi_araddr = 32'h50; I_saxi_arlen = 0; I_saxi_arid = 1'b1; I_saxi_arvalid = 1'b1;
    I_saxi_awaddr = 32'h50; I_saxi_awlen = 0; I_saxi_awid = 1'b0; I_saxi_awvalid = 1'b1;
    I_saxi_wdata = new_d; I_saxi_wstrb = 16'hFFFF; I_saxi_wlast = 2'b01; I_saxi_wvalid = 1'b1;
    I_saxi_rready = 1'b1; I_saxi_bready = 1'b1;
    @(negedge I_clk);
    chk("col_arready", O_saxi_arready, 1);
    chk("col_awready", O_saxi_awready, 1);
    @(posedge I_clk); #1;
    I_saxi_arvalid = 1'b0; I_saxi_awvalid = 1'b0;
    @(negedge I_clk);
    chk("col_wready", O_saxi_wready, 1);
    @(posedge I_clk); #1;
    I_saxi_wvalid = 1'b0;
    @(negedge I_clk);
    chk("col_rvalid", O_saxi_rvalid, 1);
    chk("col_rdata_old", O_saxi_rdata, old_d);
    chk("col_bvalid", O_saxi_bvalid, 1);
    @(posedge I_clk); #1;
    I_saxi_rready = 1'b0; I_saxi_bready = 1'b0;
    model[5] = new_d;
    axi_read(32'h50, 0, 0, 99);

    // randomized bursts
    for (int it = 0; it < 10; it++) begin
      int w, l;
      w = $urandom_range(0, DEPTH - 1);
      l = $urandom_range(0, 15);
      for (int b = 0; b <= l; b++) begin
        wbuf_d[b] = {$urandom, $urandom, $urandom, $urandom};
        wbuf_s[b] = ($urandom_range(0, 1) != 0) ? 16'hFFFF : 16'($urandom);
      end
      axi_write(32'(w * 16), l, $urandom_range(0, 5), 0);
      axi_read(32'(w * 16), l, 1, 99);
    end

    // reset while beat 2 of an 8-beat read is pending
    axi_read(32'h400, 7, 0, 1);
    @(negedge I_clk);
    @(negedge I_clk);
    chk("mid_rvalid_pending", O_saxi_rvalid, 1);
    I_rst_n = 1'b0;
    @(negedge I_clk);
    chk("mid_rst_rvalid", O_saxi_rvalid, 0);
    chk("mid_rst_arready", O_saxi_arready, 0);
    chk("mid_rst_rlast", O_saxi_rlast, 0);
    I_rst_n = 1'b1;
    @(negedge I_clk);
    chk("mid_rst_arready_up", O_saxi_arready, 1);
    chk("mid_rst_awready_up", O_saxi_awready, 1);
    @(posedge I_clk); #1;
    axi_read(32'h400, 7, 1, 99);
    axi_read(32'h100, 3, 0, 99);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
